// File: rtl/iagc_controller.sv
// Automatic gain controller: steps the gain word toward the reference amplitude
// and reports lock. Define IAGC_CONTROLLER_WATCHDOG_EN to add the MEASURE watchdog.
module iagc_controller #(
    parameter int unsigned IAGC_STATUS_SIZE     = 4,
    parameter int unsigned AMPLITUDE_DATA_SIZE  = 13,
    parameter int unsigned AMPLITUDE_COUNT_SIZE = 16,
    parameter int unsigned GAIN_SIZE            = 8,
    parameter int unsigned SAMPLE_DIV_SIZE      = 8
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic [SAMPLE_DIV_SIZE-1:0]      i_sample_div,
    input  logic [AMPLITUDE_COUNT_SIZE-1:0] i_amplitude_count_cfg,
    input  logic [AMPLITUDE_DATA_SIZE-1:0]  i_tolerance,
    input  logic [AMPLITUDE_DATA_SIZE-1:0]  i_reference_amplitude,
    input  logic [AMPLITUDE_DATA_SIZE-1:0]  i_error_amplitude,
    input  logic                            i_amp_valid,
    output logic                            o_sample,
    output logic [IAGC_STATUS_SIZE-1:0]     o_iagc_status,
    output logic [AMPLITUDE_COUNT_SIZE-1:0] o_amplitude_count,
    output logic [GAIN_SIZE-1:0]            o_gain,
    output logic                            o_locked,
    output logic                            o_timeout
);

    localparam int unsigned CMP_W = AMPLITUDE_DATA_SIZE + 1;
    localparam logic [GAIN_SIZE-1:0] GAIN_RESET = {1'b1, {(GAIN_SIZE-1){1'b0}}};
    localparam logic [GAIN_SIZE-1:0] GAIN_MAX   = '1;

    typedef enum logic [3:0] {
        ST_RESET   = 4'b0000,
        ST_INIT    = 4'b0001,
        ST_MEASURE = 4'b0010,
        ST_ADJUST  = 4'b0011,
        ST_LOCKED  = 4'b0100
    } state_t;

    state_t                            state_q, state_d;
    logic [GAIN_SIZE-1:0]              gain_d;
    logic                              locked_d;
    logic [AMPLITUDE_COUNT_SIZE-1:0]   count_d;
    logic [AMPLITUDE_DATA_SIZE-1:0]    ref_q, ref_d, err_q, err_d;
    logic [1:0]                        lock_cnt_q, lock_cnt_d, lock_inc_c;
    logic [SAMPLE_DIV_SIZE-1:0]        div_cnt_q, div_cnt_d;
    logic                              sample_d;
    logic [CMP_W-1:0]                  ref_hi_c, err_hi_c;
    logic                              force_reset_c;

`ifdef IAGC_CONTROLLER_WATCHDOG_EN
    localparam int unsigned WD_W = 21;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(1 << 20);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_expire_c;
    logic            timeout_q, timeout_d;
`endif

    assign o_iagc_status = IAGC_STATUS_SIZE'(state_q);

    // Window bounds widened by one bit so ref+tol and err+tol never wrap
    assign ref_hi_c = CMP_W'(ref_q) + CMP_W'(i_tolerance);
    assign err_hi_c = CMP_W'(err_q) + CMP_W'(i_tolerance);

    always_comb begin
        state_d    = state_q;
        gain_d     = o_gain;
        locked_d   = o_locked;
        count_d    = o_amplitude_count;
        ref_d      = ref_q;
        err_d      = err_q;
        lock_cnt_d = lock_cnt_q;
        lock_inc_c = (lock_cnt_q == 2'd3) ? 2'd3 : lock_cnt_q + 2'd1;
        div_cnt_d  = '0;
        sample_d   = 1'b0;
        force_reset_c = !i_enable;
`ifdef IAGC_CONTROLLER_WATCHDOG_EN
        wd_expire_c   = (state_q == ST_MEASURE) && (wd_cnt_q == WD_LIMIT);
        force_reset_c = force_reset_c || wd_expire_c;
        wd_cnt_d      = (state_q == ST_MEASURE && !wd_expire_c) ? wd_cnt_q + WD_W'(1) : '0;
        timeout_d     = timeout_q || wd_expire_c;
`endif

        case (state_q)
            ST_RESET: begin
                if (i_enable) state_d = ST_INIT;
            end
            ST_INIT: begin
                count_d    = i_amplitude_count_cfg;
                lock_cnt_d = 2'd0;
                state_d    = ST_MEASURE;
            end
            ST_MEASURE, ST_LOCKED: begin
                if (i_amp_valid) begin
                    ref_d   = i_reference_amplitude;
                    err_d   = i_error_amplitude;
                    state_d = ST_ADJUST;
                end
            end
            ST_ADJUST: begin
                if (CMP_W'(err_q) > ref_hi_c) begin
                    gain_d     = (o_gain == '0) ? o_gain : o_gain - GAIN_SIZE'(1);
                    lock_cnt_d = 2'd0;
                    locked_d   = 1'b0;
                    state_d    = ST_MEASURE;
                end else if (err_hi_c < CMP_W'(ref_q)) begin
                    gain_d     = (o_gain == GAIN_MAX) ? o_gain : o_gain + GAIN_SIZE'(1);
                    lock_cnt_d = 2'd0;
                    locked_d   = 1'b0;
                    state_d    = ST_MEASURE;
                end else begin
                    lock_cnt_d = lock_inc_c;
                    if (lock_inc_c == 2'd3) begin
                        locked_d = 1'b1;
                        state_d  = ST_LOCKED;
                    end else begin
                        state_d  = ST_MEASURE;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase

        // Disable (or watchdog) overrides everything, including a pending gain step
        if (force_reset_c && state_q != ST_RESET) begin
            state_d    = ST_RESET;
            gain_d     = o_gain;
            locked_d   = 1'b0;
            lock_cnt_d = 2'd0;
        end

        // Sample divider runs from the edge that leaves RESET
        if (state_d != ST_RESET) begin
            sample_d  = (div_cnt_q == '0);
            div_cnt_d = (div_cnt_q >= i_sample_div) ? '0 : div_cnt_q + SAMPLE_DIV_SIZE'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q           <= ST_RESET;
            o_gain            <= GAIN_RESET;
            o_locked          <= 1'b0;
            o_amplitude_count <= '0;
            o_sample          <= 1'b0;
            ref_q             <= '0;
            err_q             <= '0;
            lock_cnt_q        <= 2'd0;
            div_cnt_q         <= '0;
        end else begin
            state_q           <= state_d;
            o_gain            <= gain_d;
            o_locked          <= locked_d;
            o_amplitude_count <= count_d;
            o_sample          <= sample_d;
            ref_q             <= ref_d;
            err_q             <= err_d;
            lock_cnt_q        <= lock_cnt_d;
            div_cnt_q         <= div_cnt_d;
        end
    end

`ifdef IAGC_CONTROLLER_WATCHDOG_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_iagc_controller.sv
// Randomized scoreboard bench for iagc_controller: each detector result pushes the
// expected post-ADJUST gain/lock/status; a monitor compares when ADJUST completes.
module tb_iagc_controller;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [7:0]  i_sample_div;
    logic [15:0] i_amplitude_count_cfg;
    logic [12:0] i_tolerance;
    logic [12:0] i_reference_amplitude;
    logic [12:0] i_error_amplitude;
    logic        i_amp_valid;
    logic        o_sample;
    logic [3:0]  o_iagc_status;
    logic [15:0] o_amplitude_count;
    logic [7:0]  o_gain;
    logic        o_locked;
    logic        o_timeout;

    iagc_controller dut (
        .i_clock               (i_clock),
        .i_reset               (i_reset),
        .i_enable              (i_enable),
        .i_sample_div          (i_sample_div),
        .i_amplitude_count_cfg (i_amplitude_count_cfg),
        .i_tolerance           (i_tolerance),
        .i_reference_amplitude (i_reference_amplitude),
        .i_error_amplitude     (i_error_amplitude),
        .i_amp_valid           (i_amp_valid),
        .o_sample              (o_sample),
        .o_iagc_status         (o_iagc_status),
        .o_amplitude_count     (o_amplitude_count),
        .o_gain                (o_gain),
        .o_locked              (o_locked),
        .o_timeout             (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        int gain;
        int locked;
        int status;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_gain   = 128;
    int   m_lock   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!(o_iagc_status == 4'd2 || o_iagc_status == 4'd4) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: status stuck at %0d, required 2 or 4", o_iagc_status);
        end
    endtask

    // Reference behaviour of one ADJUST decision in plain integer arithmetic
    task automatic model_adjust(input int r, input int e, input int t);
        exp_t x;
        if (e > r + t) begin
            if (m_gain > 0) m_gain--;
            m_lock = 0;
        end else if (e + t < r) begin
            if (m_gain < 255) m_gain++;
            m_lock = 0;
        end else if (m_lock < 3) begin
            m_lock++;
        end
        x.gain   = m_gain;
        x.locked = (m_lock == 3) ? 1 : 0;
        x.status = (m_lock == 3) ? 4 : 2;
        exp_q.push_back(x);
    endtask

    task automatic send_amp(input int r, input int e, input int t);
        wait_ready();
        i_tolerance           = 13'(t);
        i_reference_amplitude = 13'(r);
        i_error_amplitude     = 13'(e);
        i_amp_valid           = 1'b1;
        model_adjust(r, e, t);
        tick();
        i_amp_valid = 1'b0;
        tick();
    endtask

    initial begin
        int   r, e, t, d;
        exp_t x;

        i_reset               = 1'b1;
        i_enable              = 1'b0;
        i_sample_div          = 8'd0;
        i_amplitude_count_cfg = 16'd1000;
        i_tolerance           = 13'd50;
        i_reference_amplitude = 13'd0;
        i_error_amplitude     = 13'd0;
        i_amp_valid           = 1'b0;

        fork
            begin : monitor
                int   prev;
                exp_t m;
                prev = 0;
                forever begin
                    @(negedge i_clock);
                    if (prev == 3 && o_iagc_status != 4'd3) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL scoreboard_empty: ADJUST finished with no expected entry");
                        end else begin
                            m = exp_q.pop_front();
                            check("adj_gain", int'(o_gain), m.gain);
                            check("adj_locked", int'(o_locked), m.locked);
                            check("adj_status", int'(o_iagc_status), m.status);
                        end
                    end
                    prev = int'(o_iagc_status);
                end
            end
        join_none

        tick();
        check("rst_status", int'(o_iagc_status), 0);
        check("rst_gain", int'(o_gain), 128);
        check("rst_count", int'(o_amplitude_count), 0);
        check("rst_sample", int'(o_sample), 0);
        check("rst_locked", int'(o_locked), 0);
        check("rst_timeout", int'(o_timeout), 0);
        i_reset = 1'b0;
        tick();

        // Start-up sequence 0 -> 1 -> 2
        i_enable = 1'b1;
        check("start_status0", int'(o_iagc_status), 0);
        tick();
        check("start_status1", int'(o_iagc_status), 1);
        check("start_sample_div0", int'(o_sample), 1);
        tick();
        check("start_status2", int'(o_iagc_status), 2);
        check("start_count", int'(o_amplitude_count), 1000);
        check("start_gain", int'(o_gain), 128);

        send_amp(1000, 1200, 50);

        repeat (3) send_amp(1000, 1020, 50);
        check("lock_flag", int'(o_locked), 1);
        check("lock_status", int'(o_iagc_status), 4);
        send_amp(1000, 1200, 50);

        // Saturate high, then low
        repeat (132) send_amp(1000, 100, 50);
        check("gain_sat_hi", int'(o_gain), 255);
        repeat (258) send_amp(100, 1000, 50);
        check("gain_sat_lo", int'(o_gain), 0);

        // Window edges where 13-bit sums would wrap
        send_amp(8100, 8191, 200);
        send_amp(8191, 8000, 300);
        send_amp(8191, 8191, 8191);
        send_amp(0, 8191, 8191);

        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 8191));
            t = int'($urandom_range(0, 120));
            d = int'($urandom_range(0, 400)) - 200;
            e = r + d;
            if (e < 0) e = 0;
            if (e > 8191) e = 8191;
            send_amp(r, e, t);
        end

        // Enable drop, then sample divider of 3
        i_enable = 1'b0;
        tick();
        m_lock = 0;
        check("drop_status", int'(o_iagc_status), 0);
        check("drop_sample", int'(o_sample), 0);
        check("drop_gain", int'(o_gain), m_gain);
        check("drop_locked", int'(o_locked), 0);
        i_amplitude_count_cfg = 16'd777;
        i_sample_div = 8'd3;
        i_enable = 1'b1;
        tick();
        check("div_init_status", int'(o_iagc_status), 1);
        check("div_sample_k0", int'(o_sample), 1);
        for (int k = 1; k < 12; k++) begin
            tick();
            if (k == 1) check("relatch_count", int'(o_amplitude_count), 777);
            check($sformatf("div_sample_k%0d", k), int'(o_sample), (k % 4 == 0) ? 1 : 0);
        end
        i_enable = 1'b0;
        tick();
        check("drop2_status", int'(o_iagc_status), 0);
        check("drop2_sample", int'(o_sample), 0);
        check("drop2_gain", int'(o_gain), m_gain);

        // Enable dropped during ADJUST: pending step is discarded
        i_sample_div = 8'd0;
        i_enable = 1'b1;
        wait_ready();
        i_tolerance           = 13'd50;
        i_reference_amplitude = 13'd1000;
        i_error_amplitude     = 13'd100;
        i_amp_valid           = 1'b1;
        x.gain = m_gain; x.locked = 0; x.status = 0;
        exp_q.push_back(x);
        tick();
        i_amp_valid = 1'b0;
        i_enable    = 1'b0;
        tick();
        check("adj_drop_gain", int'(o_gain), m_gain);
        i_enable = 1'b1;
        wait_ready();

        // Reset in the middle of ADJUST
        i_reference_amplitude = 13'd1000;
        i_error_amplitude     = 13'd1200;
        i_amp_valid           = 1'b1;
        x.gain = 128; x.locked = 0; x.status = 0;
        exp_q.push_back(x);
        tick();
        i_amp_valid = 1'b0;
        @(negedge i_clock);
        #1;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        m_gain = 128;
        m_lock = 0;
        check("adj_reset_gain", int'(o_gain), 128);
        check("adj_reset_status", int'(o_iagc_status), 0);
        send_amp(1000, 1020, 50);
        tick();
        tick();
        check("queue_drain", exp_q.size(), 0);
        check("timeout_off", int'(o_timeout), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
